// File: rtl/asmi_readback.sv
// Streams flash pages from the ALTASMI parallel read port into the Tx FIFO with a running checksum.
// Optional: define ASMI_READ_TIMEOUT_EN to abort a readback when block_ready is never acknowledged.
module asmi_readback #(
  parameter logic [23:0] START_ADDR = 24'h200000,
  parameter int          PAGE_BYTES = 256,
  parameter int          FIFO_ROOM  = 1792
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        read_req,
  input  logic [13:0] num_blocks,
  output logic        read_ACK,
  output logic [23:0] asmi_addr,
  output logic        asmi_read,
  output logic        asmi_rden,
  input  logic [7:0]  asmi_dataout,
  input  logic        asmi_data_valid,
  input  logic        asmi_busy,
  input  logic [10:0] tx_used,
  output logic        tx_wrreq,
  output logic [7:0]  tx_data,
  output logic        block_ready,
  input  logic        block_ready_ACK,
  output logic        read_done,
  output logic [15:0] checksum,
  output logic [2:0]  fsm_state
);

  typedef enum logic [2:0] {
    IDLE, ACCEPT, START, BURST, STOP, NOTIFY, NEXT, DONE
  } state_t;

  localparam logic [8:0]  LAST_BYTE = 9'(PAGE_BYTES - 1);
  localparam logic [23:0] ADDR_STEP = 24'(PAGE_BYTES);
  localparam logic [11:0] ROOM      = 12'(FIFO_ROOM);

`ifdef ASMI_READ_TIMEOUT_EN
  localparam logic [24:0] TIMEOUT_LAST = 25'(25_000_000 - 1);
  logic [24:0] wait_count;
`endif

  state_t      state;
  logic [13:0] nblk;
  logic [13:0] page;
  logic [8:0]  byte_count;
  logic [7:0]  rev_byte;
  logic        room_ok;

  assign fsm_state = state;
  assign room_ok   = ({1'b0, tx_used} < ROOM);

  // Flash delivers LSB-first; the Tx side expects MSB-first.
  always_comb begin
    rev_byte = '0;
    for (int i = 0; i < 8; i++) rev_byte[i] = asmi_dataout[7-i];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      read_ACK    <= 1'b0;
      asmi_addr   <= START_ADDR;
      asmi_read   <= 1'b0;
      asmi_rden   <= 1'b0;
      tx_wrreq    <= 1'b0;
      tx_data     <= '0;
      block_ready <= 1'b0;
      read_done   <= 1'b0;
      checksum    <= '0;
      nblk        <= '0;
      page        <= '0;
      byte_count  <= '0;
`ifdef ASMI_READ_TIMEOUT_EN
      wait_count  <= '0;
`endif
    end else begin
      read_ACK  <= 1'b0;
      asmi_read <= 1'b0;
      tx_wrreq  <= 1'b0;
      case (state)
        IDLE: begin
          if (read_req) begin
            nblk      <= num_blocks;
            asmi_addr <= START_ADDR;
            page      <= '0;
            checksum  <= '0;
            read_done <= 1'b0;
            state     <= ACCEPT;
          end
        end
        ACCEPT: begin
          read_ACK <= 1'b1;
          state    <= (nblk == '0) ? DONE : START;
        end
        START: begin
          if (!asmi_busy && room_ok) begin
            asmi_read  <= 1'b1;
            asmi_rden  <= 1'b1;
            byte_count <= '0;
            state      <= BURST;
          end
        end
        BURST: begin
          // Bytes beyond the page end are dropped by leaving BURST on the last one.
          if (asmi_data_valid) begin
            tx_data    <= rev_byte;
            tx_wrreq   <= 1'b1;
            checksum   <= checksum + {8'h00, rev_byte};
            byte_count <= byte_count + 9'd1;
            if (byte_count == LAST_BYTE) begin
              asmi_rden <= 1'b0;
              state     <= STOP;
            end
          end
        end
        STOP: begin
          if (!asmi_busy) begin
            block_ready <= 1'b1;
`ifdef ASMI_READ_TIMEOUT_EN
            wait_count  <= '0;
`endif
            state       <= NOTIFY;
          end
        end
        NOTIFY: begin
          if (block_ready_ACK) begin
            block_ready <= 1'b0;
            page        <= page + 14'd1;
            asmi_addr   <= asmi_addr + ADDR_STEP;
            state       <= NEXT;
          end
`ifdef ASMI_READ_TIMEOUT_EN
          else if (wait_count == TIMEOUT_LAST) begin
            block_ready <= 1'b0;
            state       <= IDLE;
          end else begin
            wait_count <= wait_count + 25'd1;
          end
`endif
        end
        NEXT: begin
          state <= (page == nblk) ? DONE : START;
        end
        DONE: begin
          read_done <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_asmi_readback.sv
// Directed bench for asmi_readback: vector table of whole readbacks plus hand sequences
// for FIFO-room throttling and reset in the middle of a burst.
module tb_asmi_readback;

  localparam logic [23:0] START_ADDR = 24'h200000;
  localparam int EXTRA     = 4;   // data_valid stays high this many bytes past the page end
  localparam int ACK_DELAY = 10;
  localparam int WAIT_MAX  = 20000;

  logic        clk = 1'b0;
  logic        reset;
  logic        read_req;
  logic [13:0] num_blocks;
  logic        read_ACK;
  logic [23:0] asmi_addr;
  logic        asmi_read;
  logic        asmi_rden;
  logic [7:0]  asmi_dataout;
  logic        asmi_data_valid;
  logic        asmi_busy;
  logic [10:0] tx_used;
  logic        tx_wrreq;
  logic [7:0]  tx_data;
  logic        block_ready;
  logic        block_ready_ACK;
  logic        read_done;
  logic [15:0] checksum;
  logic [2:0]  fsm_state;

  asmi_readback dut (
    .clock(clk), .reset(reset), .read_req(read_req), .num_blocks(num_blocks),
    .read_ACK(read_ACK), .asmi_addr(asmi_addr), .asmi_read(asmi_read),
    .asmi_rden(asmi_rden), .asmi_dataout(asmi_dataout),
    .asmi_data_valid(asmi_data_valid), .asmi_busy(asmi_busy), .tx_used(tx_used),
    .tx_wrreq(tx_wrreq), .tx_data(tx_data), .block_ready(block_ready),
    .block_ready_ACK(block_ready_ACK), .read_done(read_done), .checksum(checksum),
    .fsm_state(fsm_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int errors = 0;
  int checks = 0;
  int cur_mode = 0;

  // Updated only by the environment process.
  logic [7:0]  exp_q[$];
  logic [23:0] addr_log[int];
  int          wr_total = 0, read_total = 0, ack_total = 0, blk_total = 0;
  int          data_err = 0, cs_err = 0, guard_err = 0, br_err = 0;
  logic [15:0] sum_model = '0;

  typedef struct {
    logic [13:0] nblk;
    int          mode;
    int          exp_wr;
    logic [15:0] exp_cs;
  } vec_t;

  vec_t vecs[5];

  function automatic logic [7:0] bitrev(input logic [7:0] b);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r[7-i] = b[i];
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- environment: ASMI model, Tx ACK model, monitor ----------------
  initial begin : env
    int burst_left;
    int byte_pos;
    int busy_left;
    int ack_cnt;
    logic [7:0] b;
    logic [7:0] e;
    burst_left = 0; byte_pos = 0; busy_left = 0; ack_cnt = 0;
    asmi_dataout = '0; asmi_data_valid = 1'b0; asmi_busy = 1'b0; block_ready_ACK = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        exp_q.delete();
        burst_left = 0; busy_left = 0; ack_cnt = 0;
        sum_model = '0;
        asmi_data_valid = 1'b0; asmi_busy = 1'b0; block_ready_ACK = 1'b0;
      end else begin
        if (read_ACK) begin
          ack_total++;
          sum_model = '0;
        end
        if (tx_wrreq) begin
          wr_total++;
          if (exp_q.size() == 0) data_err++;
          else begin
            e = exp_q.pop_front();
            if (tx_data !== e) data_err++;
            sum_model = sum_model + {8'h00, e};
          end
          if (checksum !== sum_model) cs_err++;
        end
        if (asmi_read) begin
          if (asmi_busy || tx_used >= 11'd1792) guard_err++;
          addr_log[read_total] = asmi_addr;
          read_total++;
          burst_left = 256 + EXTRA;
          byte_pos = 0;
        end
        if (block_ready && tx_wrreq) br_err++;
        if (block_ready_ACK) begin
          block_ready_ACK = 1'b0;
          if (block_ready) br_err++;
        end else if (block_ready) begin
          if (ack_cnt == ACK_DELAY - 1) begin
            block_ready_ACK = 1'b1;
            ack_cnt = 0;
            blk_total++;
          end else ack_cnt++;
        end
        if (burst_left > 0) begin
          if (burst_left > EXTRA) b = (cur_mode == 0) ? 8'(byte_pos + 1) : 8'h01;
          else b = 8'hEE;
          asmi_dataout = b;
          asmi_data_valid = 1'b1;
          asmi_busy = (burst_left <= EXTRA);
          if (burst_left > EXTRA) exp_q.push_back(bitrev(b));
          byte_pos++;
          burst_left--;
          if (burst_left == 0) busy_left = 3;
        end else begin
          asmi_data_valid = 1'b0;
          if (busy_left > 0) begin
            asmi_busy = 1'b1;
            busy_left--;
          end else asmi_busy = 1'b0;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic pulse_req(input logic [13:0] nblk, input int mode);
    @(negedge clk);
    num_blocks = nblk;
    cur_mode = mode;
    read_req = 1'b1;
    @(negedge clk);
    read_req = 1'b0;
    num_blocks = 14'h3FFF;  // must already be latched
  endtask

  task automatic wait_done(input logic [13:0] nblk);
    for (int i = 0; i < WAIT_MAX; i++) begin
      @(negedge clk);
      if (i == 30 && nblk != 0) read_req = 1'b1;  // ignored outside IDLE
      else read_req = 1'b0;
      if (read_done && i > 31) break;
    end
    read_req = 1'b0;
  endtask

  task automatic run_case(input vec_t v, input int idx);
    int wr0, rd0, ack0, blk0, de0, ce0;
    string tag;
    tag = $sformatf("v%0d", idx);
    wr0 = wr_total; rd0 = read_total; ack0 = ack_total; blk0 = blk_total;
    de0 = data_err; ce0 = cs_err;
    pulse_req(v.nblk, v.mode);
    @(negedge clk);
    check({tag, "_ack_latency"}, 32'(read_ACK), 32'd1);
    wait_done(v.nblk);
    check({tag, "_read_done"}, 32'(read_done), 32'd1);
    check({tag, "_wrreq_count"}, 32'(wr_total - wr0), 32'(v.exp_wr));
    check({tag, "_checksum"}, 32'(checksum), 32'(v.exp_cs));
    check({tag, "_asmi_reads"}, 32'(read_total - rd0), 32'(v.nblk));
    check({tag, "_pages_acked"}, 32'(blk_total - blk0), 32'(v.nblk));
    check({tag, "_ack_pulses"}, 32'(ack_total - ack0), 32'd1);
    check({tag, "_data_errs"}, 32'(data_err - de0), 32'd0);
    check({tag, "_cs_track_errs"}, 32'(cs_err - ce0), 32'd0);
    for (int k = 0; k < int'(v.nblk); k++)
      if (addr_log.exists(rd0 + k))
        check($sformatf("%s_addr%0d", tag, k), 32'(addr_log[rd0 + k]), 32'(START_ADDR + 24'(256 * k)));
    repeat (3) @(negedge clk);
    check({tag, "_done_hold"}, 32'(read_done), 32'd1);
  endtask

  // ---------------- test ----------------
  initial begin : main
    int wr0, rd0;
    vecs[0] = '{nblk: 14'd2, mode: 0, exp_wr: 512, exp_cs: 16'hFF00};
    vecs[1] = '{nblk: 14'd2, mode: 1, exp_wr: 512, exp_cs: 16'h0000};
    vecs[2] = '{nblk: 14'd0, mode: 0, exp_wr: 0,   exp_cs: 16'h0000};
    vecs[3] = '{nblk: 14'd1, mode: 1, exp_wr: 256, exp_cs: 16'h8000};
    vecs[4] = '{nblk: 14'd3, mode: 0, exp_wr: 768, exp_cs: 16'h7E80};

    reset = 1'b1; read_req = 1'b0; num_blocks = '0; tx_used = '0;
    repeat (3) @(negedge clk);
    check("rst_state", 32'(fsm_state), 32'd0);
    check("rst_addr", 32'(asmi_addr), 32'(START_ADDR));
    check("rst_outs", 32'({read_ACK, asmi_read, asmi_rden, tx_wrreq, block_ready, read_done}), 32'd0);
    check("rst_data_cs", 32'({tx_data, checksum}), 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 5; i++) run_case(vecs[i], i);

    // FIFO room throttling, including the exact threshold.
    wr0 = wr_total; rd0 = read_total;
    tx_used = 11'd1800;
    pulse_req(14'd1, 1);
    repeat (12) @(negedge clk);
    check("throttle_1800", 32'(read_total - rd0), 32'd0);
    tx_used = 11'd1792;
    repeat (8) @(negedge clk);
    check("throttle_1792", 32'(read_total - rd0), 32'd0);
    tx_used = 11'd1791;
    repeat (2) @(negedge clk);
    check("read_after_room", 32'(read_total - rd0), 32'd1);
    tx_used = 11'd1000;
    wait_done(14'd1);
    check("throttle_wr", 32'(wr_total - wr0), 32'd256);
    check("throttle_cs", 32'(checksum), 32'h8000);
    check("guard_errs", 32'(guard_err), 32'd0);

    // Reset after 100 bytes of a burst.
    wr0 = wr_total;
    pulse_req(14'd2, 0);
    for (int i = 0; i < WAIT_MAX; i++) begin
      @(negedge clk);
      if (wr_total - wr0 >= 100) break;
    end
    check("reached_100", 32'(wr_total - wr0 >= 100), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_rden", 32'(asmi_rden), 32'd0);
    check("midrst_wrreq", 32'(tx_wrreq), 32'd0);
    check("midrst_cs", 32'(checksum), 32'd0);
    check("midrst_state", 32'(fsm_state), 32'd0);
    check("midrst_addr", 32'(asmi_addr), 32'(START_ADDR));
    reset = 1'b0;
    repeat (2) @(negedge clk);
    run_case(vecs[3], 5);

    check("block_ready_errs", 32'(br_err), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/asmi_readback.md
# asmi_readback

Streams a region of the EPCS configuration flash back to the host through the ALTASMI parallel read port, so the PC can verify an image after programming. Sits beside the flash-programming block on the same ASMI megafunction and feeds the Tx FIFO in 256-byte pages. Maintains a running 16-bit checksum of the bytes sent. Exchanges page-level handshakes with the Tx packet builder.

## Interface
- Parameters:
  - START_ADDR, 24'h200000: first flash byte address read.
  - PAGE_BYTES, 256: bytes per page and per handshake.
  - FIFO_ROOM, 1792: a page starts only if tx_used < FIFO_ROOM.
- Ports:
  - clock  in  1  system clock, all logic on posedge.
  - reset  in  1  synchronous, active-high.
  - read_req  in  1  PC requests a readback; sampled in IDLE only.
  - num_blocks  in  14  pages to read; latched on read_req acceptance.
  - read_ACK  out  1  one-cycle pulse: request accepted.
  - asmi_addr  out  24  flash read address.
  - asmi_read  out  1  one-cycle pulse that loads asmi_addr.
  - asmi_rden  out  1  held high for a whole page burst.
  - asmi_dataout  in  8  flash byte, LSB-first order.
  - asmi_data_valid  in  1  asmi_dataout valid this cycle.
  - asmi_busy  in  1  ASMI busy.
  - tx_used  in  11  Tx FIFO fill level.
  - tx_wrreq  out  1  Tx FIFO write strobe.
  - tx_data  out  8  byte to Tx FIFO, MSB-first (bit-reversed asmi_dataout).
  - block_ready  out  1  page in FIFO; held until block_ready_ACK.
  - block_ready_ACK  in  1  Tx has seen block_ready.
  - read_done  out  1  high after the last page is acknowledged, until next read_req.
  - checksum  out  16  sum of tx_data bytes mod 2^16.

## Operation
- States: IDLE, ACCEPT, START, BURST, STOP, NOTIFY, NEXT, DONE.
- IDLE: outputs quiescent.
  - On read_req: latch num_blocks, asmi_addr = START_ADDR, page = 0, checksum = 0, read_done = 0.
  - Go to ACCEPT.
- ACCEPT: read_ACK = 1 for one cycle.
  - If latched num_blocks == 0, go to DONE.
  - Otherwise go to START.
- START: wait for !asmi_busy && tx_used < FIFO_ROOM, then assert asmi_read for one cycle with asmi_rden = 1. Go to BURST.
- BURST: for each asmi_data_valid:
  - Register the reversed byte into tx_data and assert tx_wrreq on the next cycle.
  - checksum += reversed byte.
  - byte_count++ (9-bit).
  - When byte_count reaches PAGE_BYTES, drop asmi_rden and go to STOP. No further bytes are written even if data_valid stays high.
- STOP: wait for !asmi_busy, then set block_ready = 1. Go to NOTIFY.
- NOTIFY: on block_ready_ACK, clear block_ready, page++, asmi_addr += 256. Go to NEXT.
- NEXT: if page == num_blocks, go to DONE; else go to START.
- DONE: read_done = 1. Return to IDLE. read_done stays high until the next read_req is accepted.
- read_req while not IDLE: ignored.
- asmi_addr wraps modulo 2^24. Not checked.
- Reset at any point, including mid-burst: state = IDLE and all outputs take their reset values within one clock.
  - Reset values: all 1-bit outputs 0, asmi_addr = START_ADDR, tx_data = 0, checksum = 0.

## Timing
- read_req to read_ACK: 2 cycles (IDLE register, ACCEPT).
- asmi_data_valid to tx_wrreq: 1 cycle. Exactly PAGE_BYTES tx_wrreq pulses per page.
- checksum updates in the same cycle as the matching tx_wrreq.
- block_ready rises at least 1 cycle after the last tx_wrreq of its page.
- block_ready falls the cycle after block_ready_ACK is sampled.
- block_ready_ACK and reset asserted together: reset wins.
- asmi_read never asserts while asmi_busy = 1 or tx_used >= FIFO_ROOM.

## Configuration
- ASMI_READ_TIMEOUT_EN defined:
  - NOTIFY counts clocks in a 25-bit counter.
  - If block_ready_ACK is not seen within 25,000,000 clocks, clear block_ready, leave read_done = 0 and return to IDLE (abort).
- ASMI_READ_TIMEOUT_EN undefined: NOTIFY waits indefinitely and no counter is built.

## Test plan
- read_req with num_blocks = 2; ASMI model returns bytes 0x01..0x00 twice; ACK each block_ready after 10 clocks:
  - 512 tx_wrreq pulses.
  - tx_data is the bit-reverse of each byte (0x01 -> 0x80).
  - asmi_read addresses are 0x200000, then 0x200100.
  - read_done = 1.
- Checksum: all bytes 0x01 (tx_data 0x80) for 2 pages -> checksum = 0x0000 (512 × 0x80 = 0x10000, wraps).
- num_blocks = 0 -> read_ACK pulse, read_done high, zero asmi_read and zero tx_wrreq.
- Hold tx_used = 1800 with asmi_busy = 0 -> no asmi_read. Drop tx_used to 1000 -> asmi_read within 2 cycles.
- Reset after 100 bytes of a burst -> asmi_rden = 0, tx_wrreq = 0, checksum = 0 the next cycle. A new read_req restarts at 0x200000.
- With ASMI_READ_TIMEOUT_EN, never assert block_ready_ACK -> block_ready drops after 25,000,000 clocks, state returns to IDLE, read_done = 0.
